// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch squash, mult/div EX occupancy.
// Enables/flushes are combinational (same-cycle); FSM, md counter and stall counter are registered.
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MCW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t         state;
  logic [MCW-1:0] md_cnt;
  logic           load_use;
  logic           md_stall;

  assign load_use = idex_mem_read && (idex_rt != 5'd0) &&
                    ((id_uses_rs && (idex_rt == id_rs)) ||
                     (id_uses_rt && (idex_rt == id_rt)));

  // The release cycle (MD_BUSY with md_cnt==0) ignores ex_md_start: the same op is still in EX.
  assign md_stall = !rst && (((state == RUN) && ex_md_start) ||
                             ((state == MD_BUSY) && (md_cnt != '0)));

  assign md_busy = (state == MD_BUSY);

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    if (!rst) begin
      if (md_stall) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ex_md_start) begin
            state  <= MD_BUSY;
            md_cnt <= MCW'(MD_LATENCY - 2);
          end
        end
        MD_BUSY: begin
          if (md_cnt != '0) begin
            md_cnt <= md_cnt - MCW'(1);
          end else begin
            state <= RUN;
          end
        end
        default: begin
          state  <= RUN;
          md_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second instance with a 4-bit counter covers saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, idex_rt;
  logic        id_uses_rs, id_uses_rt, idex_mem_read, ex_branch_taken, ex_md_start;

  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, md_busy;
  logic [15:0] stall_cycles;

  logic        pc_write4, ifid_write4, ifid_flush4, idex_write4, idex_bubble4, exmem_bubble4, md_busy4;
  logic [3:0]  stall_cycles4;

  int errors = 0;
  int checks = 0;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, md_busy}
  localparam logic [6:0] O_NORM    = 7'b1101000;
  localparam logic [6:0] O_LU      = 7'b0001100;
  localparam logic [6:0] O_BR      = 7'b1111100;
  localparam logic [6:0] O_MD0     = 7'b0000010;
  localparam logic [6:0] O_MDB     = 7'b0000011;
  localparam logic [6:0] O_REL     = 7'b1101001;
  localparam logic [6:0] O_REL_BR  = 7'b1111101;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .pc_write(pc_write4), .ifid_write(ifid_write4), .ifid_flush(ifid_flush4),
    .idex_write(idex_write4), .idex_bubble(idex_bubble4), .exmem_bubble(exmem_bubble4),
    .md_busy(md_busy4), .stall_cycles(stall_cycles4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {25'd0, pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, md_busy};
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic mr, input logic [4:0] exrt, input logic br, input logic md);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    idex_mem_read = mr; idex_rt = exrt; ex_branch_taken = br; ex_md_start = md;
  endtask

  // Check combinational outputs mid-cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [6:0] exp);
    #1;
    chk(tag, outs(), {25'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    // Hazard-provoking inputs while in reset: outputs must still be forced.
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
    #2;
    chk("rst_outs", outs(), {25'd0, O_NORM});
    chk("rst_sc", stall_cycles, 0);
    @(posedge clk); #1;
    chk("rst_hold_outs", outs(), {25'd0, O_NORM});
    chk("rst_hold_sc", stall_cycles, 0);
    rst = 1'b0;

    // T1: load-use on rs, then clean cycle
    drive(5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    cyc("t1_lu_rs", O_LU);
    chk("t1_sc", stall_cycles, 1);
    drive(5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("t1_clean", O_NORM);
    chk("t1_sc_hold", stall_cycles, 1);

    // Load-use via rt path, then same regs but not read
    drive(5'd9, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    cyc("t1_lu_rt", O_LU);
    drive(5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    cyc("t1_unused", O_NORM);
    chk("t1_sc2", stall_cycles, 2);

    // T2: $0 never hazards
    drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc("t2_r0", O_NORM);

    // T3: branch squash overrides load-use
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
    cyc("t3_br_lu", O_BR);
    chk("t3_sc", stall_cycles, 2);

    // T4: mult/div held 4 cycles
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    cyc("t4_c0", O_MD0);
    cyc("t4_c1", O_MDB);
    cyc("t4_c2", O_MDB);
    cyc("t4_c3", O_REL);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("t4_run", O_NORM);
    chk("t4_sc", stall_cycles, 5);

    // MD with branch held: branch ignored until release cycle
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    cyc("t4b_c0", O_MD0);
    cyc("t4b_c1", O_MDB);
    cyc("t4b_c2", O_MDB);
    cyc("t4b_c3", O_REL_BR);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("t4b_run", O_NORM);
    chk("t4b_sc", stall_cycles, 8);

    // T5: reset while MD_BUSY with md_cnt==1
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    cyc("t5_c0", O_MD0);
    cyc("t5_c1", O_MDB);
    chk("t5_sc_pre", stall_cycles, 10);
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", outs(), {25'd0, O_NORM});
    chk("t5_rst_sc", stall_cycles, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("t5_r0", O_MD0);
    cyc("t5_r1", O_MDB);
    cyc("t5_r2", O_MDB);
    cyc("t5_r3", O_REL);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("t5_run", O_NORM);
    chk("t5_sc", stall_cycles, 3);
    chk("t5_sc4", stall_cycles4, 3);

    // T6: hold a load-use stall 20 cycles; 4-bit counter saturates at 15
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 10) chk("t6_sc4_14", stall_cycles4, 14);
      if (i == 11) chk("t6_sc4_15", stall_cycles4, 15);
    end
    chk("t6_sc4_sat", stall_cycles4, 15);
    chk("t6_sc16", stall_cycles, 23);
    chk("t6_outs", outs(), {25'd0, O_LU});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
